// File: rtl/hazard_dest_pipe_pkg.sv
// Shared types and constants for the decode-hazard destination pipeline.
package hazard_dest_pipe_pkg;

  localparam int P_ADDR_W = 5;
  localparam int P_TNEW_W = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  typedef struct packed {
    logic [P_ADDR_W-1:0] addr;
    logic [P_TNEW_W-1:0] tnew;
    logic [P_ADDR_W-1:0] rs;
    logic [P_ADDR_W-1:0] rt;
  } stage_t;

  localparam stage_t BUBBLE = '{addr: '0, tnew: '0, rs: '0, rt: '0};

  // Forwarding select for one source operand. M wins over W because it
  // holds the youngest producer; an M match whose result is not ready yet
  // falls through to W. Register 0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [P_ADDR_W-1:0] src,
    input logic [P_ADDR_W-1:0] m_addr,
    input logic [P_TNEW_W-1:0] m_tnew,
    input logic [P_ADDR_W-1:0] w_addr
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != '0 && src == m_addr && m_tnew == '0) begin
      sel = FWD_M;
    end else if (src != '0 && src == w_addr) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage register holding {addr, tnew, rs, rt}, with bubble
// insertion and an optional saturating Tnew decrement applied on load.
module hazard_stage_reg
  import hazard_dest_pipe_pkg::*;
#(
  parameter bit DEC_TNEW = 1'b0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  logic   bubble_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t stage_d;
  stage_t stage_q;

  // Next-state: hold, or load the incoming tuple / a bubble, aging Tnew.
  always_comb begin
    stage_d = stage_q;
    if (en_i) begin
      stage_d = bubble_i ? BUBBLE : d_i;
      if (DEC_TNEW && stage_d.tnew != '0) begin
        stage_d.tnew = stage_d.tnew - P_TNEW_W'(1);
      end
    end
  end

  // State register, cleared asynchronously to a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/hazard_dest_pipe.sv
// Carries destination/Tnew/rs/rt of issued instructions down E/M/W and
// produces the E- and M-stage forwarding selects from the stage registers.
module hazard_dest_pipe
  import hazard_dest_pipe_pkg::*;
#(
  parameter int ADDR_W = P_ADDR_W,
  parameter int TNEW_W = P_TNEW_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [ADDR_W-1:0] reg_addr_D,
  input  logic [TNEW_W-1:0] Tnew_D,
  input  logic [ADDR_W-1:0] rs_D,
  input  logic [ADDR_W-1:0] rt_D,
  output logic [ADDR_W-1:0] reg_addr_E,
  output logic [ADDR_W-1:0] reg_addr_M,
  output logic [ADDR_W-1:0] reg_addr_W,
  output logic [TNEW_W-1:0] Tnew_E,
  output logic [TNEW_W-1:0] Tnew_M,
  output logic [ADDR_W-1:0] rs_E,
  output logic [ADDR_W-1:0] rt_E,
  output logic [ADDR_W-1:0] rt_M,
  output logic [1:0]        fwd_rs_E_op,
  output logic [1:0]        fwd_rt_E_op,
  output logic              fwd_rt_M_op
);

  stage_t d_stage;
  stage_t e_q;
  stage_t m_q;
  stage_t w_in;
  stage_t w_q;

  assign d_stage = '{addr: reg_addr_D, tnew: Tnew_D, rs: rs_D, rt: rt_D};
  // W only needs the destination and the store-data register.
  assign w_in    = '{addr: m_q.addr, tnew: '0, rs: '0, rt: m_q.rt};

  hazard_stage_reg #(.DEC_TNEW(1'b0)) u_stage_e (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (1'b1),
    .bubble_i (stall),
    .d_i      (d_stage),
    .q_o      (e_q)
  );

  hazard_stage_reg #(.DEC_TNEW(1'b1)) u_stage_m (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (1'b1),
    .bubble_i (1'b0),
    .d_i      (e_q),
    .q_o      (m_q)
  );

  hazard_stage_reg #(.DEC_TNEW(1'b0)) u_stage_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (1'b1),
    .bubble_i (1'b0),
    .d_i      (w_in),
    .q_o      (w_q)
  );

  assign reg_addr_E = e_q.addr;
  assign reg_addr_M = m_q.addr;
  assign reg_addr_W = w_q.addr;
  assign Tnew_E     = e_q.tnew;
  assign Tnew_M     = m_q.tnew;
  assign rs_E       = e_q.rs;
  assign rt_E       = e_q.rt;
  assign rt_M       = m_q.rt;

  // Forwarding selects, purely from stage-register contents.
  always_comb begin
    fwd_rs_E_op = fwd_sel(e_q.rs, m_q.addr, m_q.tnew, w_q.addr);
    fwd_rt_E_op = fwd_sel(e_q.rt, m_q.addr, m_q.tnew, w_q.addr);
    fwd_rt_M_op = (m_q.rt != '0) && (m_q.rt == w_q.addr);
  end

  // Fields carried but not consumed past their stage.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{m_q.rs, w_q.tnew, w_q.rs, w_q.rt};

endmodule

// File: tb/tb_hazard_dest_pipe.sv
// Directed bench for hazard_dest_pipe with a queue-style reference model.
module tb_hazard_dest_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic [4:0] reg_addr_D = '0;
  logic [1:0] Tnew_D = '0;
  logic [4:0] rs_D = '0;
  logic [4:0] rt_D = '0;
  logic [4:0] reg_addr_E, reg_addr_M, reg_addr_W;
  logic [1:0] Tnew_E, Tnew_M;
  logic [4:0] rs_E, rt_E, rt_M;
  logic [1:0] fwd_rs_E_op, fwd_rt_E_op;
  logic       fwd_rt_M_op;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  hazard_dest_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .reg_addr_D  (reg_addr_D),
    .Tnew_D      (Tnew_D),
    .rs_D        (rs_D),
    .rt_D        (rt_D),
    .reg_addr_E  (reg_addr_E),
    .reg_addr_M  (reg_addr_M),
    .reg_addr_W  (reg_addr_W),
    .Tnew_E      (Tnew_E),
    .Tnew_M      (Tnew_M),
    .rs_E        (rs_E),
    .rt_E        (rt_E),
    .rt_M        (rt_M),
    .fwd_rs_E_op (fwd_rs_E_op),
    .fwd_rt_E_op (fwd_rt_E_op),
    .fwd_rt_M_op (fwd_rt_M_op)
  );

  always #5 clk = ~clk;

  // Reference model: age[k] is the tuple issued k+1 edges ago (bubble on stall).
  typedef struct {
    int addr;
    int tnew;
    int rs;
    int rt;
  } tup_t;

  tup_t age [3];

  initial begin
    for (int i = 0; i < 3; i++) age[i] = '{0, 0, 0, 0};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) age[i] <= '{0, 0, 0, 0};
    end else begin
      age[2] <= age[1];
      age[1] <= age[0];
      if (stall) age[0] <= '{0, 0, 0, 0};
      else       age[0] <= '{int'(reg_addr_D), int'(Tnew_D), int'(rs_D), int'(rt_D)};
    end
  end

  function automatic int exp_fwd(int src, int m_addr, int m_tnew, int w_addr);
    if (src != 0 && src == m_addr && m_tnew == 0) return 2;
    if (src != 0 && src == w_addr) return 1;
    return 0;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      int m_tnew;
      m_tnew = (age[1].tnew > 0) ? age[1].tnew - 1 : 0;
      check("m_reg_addr_E", int'(reg_addr_E), age[0].addr);
      check("m_Tnew_E",     int'(Tnew_E),     age[0].tnew);
      check("m_rs_E",       int'(rs_E),       age[0].rs);
      check("m_rt_E",       int'(rt_E),       age[0].rt);
      check("m_reg_addr_M", int'(reg_addr_M), age[1].addr);
      check("m_Tnew_M",     int'(Tnew_M),     m_tnew);
      check("m_rt_M",       int'(rt_M),       age[1].rt);
      check("m_reg_addr_W", int'(reg_addr_W), age[2].addr);
      check("m_fwd_rs_E",   int'(fwd_rs_E_op),
            exp_fwd(age[0].rs, age[1].addr, m_tnew, age[2].addr));
      check("m_fwd_rt_E",   int'(fwd_rt_E_op),
            exp_fwd(age[0].rt, age[1].addr, m_tnew, age[2].addr));
      check("m_fwd_rt_M",   int'(fwd_rt_M_op),
            (age[1].rt != 0 && age[1].rt == age[2].addr) ? 1 : 0);
    end
  end

  // Drive one D-stage tuple at a negedge; return at the next negedge.
  task automatic issue(input bit st, input int a, input int tn, input int rs, input int rt);
    stall      = st;
    reg_addr_D = 5'(a);
    Tnew_D     = 2'(tn);
    rs_D       = 5'(rs);
    rt_D       = 5'(rt);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr_E"}, int'(reg_addr_E), 0);
    check({tag, "_addr_M"}, int'(reg_addr_M), 0);
    check({tag, "_addr_W"}, int'(reg_addr_W), 0);
    check({tag, "_Tnew_E"}, int'(Tnew_E), 0);
    check({tag, "_Tnew_M"}, int'(Tnew_M), 0);
    check({tag, "_rs_E"},   int'(rs_E), 0);
    check({tag, "_rt_E"},   int'(rt_E), 0);
    check({tag, "_rt_M"},   int'(rt_M), 0);
    check({tag, "_fwd_rs"}, int'(fwd_rs_E_op), 0);
    check({tag, "_fwd_rt"}, int'(fwd_rt_E_op), 0);
    check({tag, "_fwd_rtM"}, int'(fwd_rt_M_op), 0);
  endtask

  initial begin
    #3;
    check_all_zero("rst0");
    @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Latency and Tnew aging of a load.
    issue(0, 8, 2, 0, 0);
    check("ld_addr_E", int'(reg_addr_E), 8);
    check("ld_Tnew_E", int'(Tnew_E), 2);
    issue(0, 0, 0, 0, 0);
    check("ld_addr_M", int'(reg_addr_M), 8);
    check("ld_Tnew_M", int'(Tnew_M), 1);
    issue(0, 0, 0, 0, 0);
    check("ld_addr_W", int'(reg_addr_W), 8);

    // ALU producer then dependent consumer: forward from M.
    issue(0, 9, 1, 0, 0);
    issue(0, 0, 0, 9, 0);
    check("alu_Tnew_M", int'(Tnew_M), 0);
    check("alu_fwd_rs_M", int'(fwd_rs_E_op), 2);
    issue(0, 0, 0, 0, 0);
    check("alu_addr_W", int'(reg_addr_W), 9);
    check("alu_fwd_rs_after", int'(fwd_rs_E_op), 0);

    // Two stalled cycles: bubbles in E, older entries drain.
    issue(0, 12, 0, 0, 0);
    issue(0, 13, 0, 0, 0);
    issue(1, 4, 1, 0, 0);
    check("st1_addr_E", int'(reg_addr_E), 0);
    check("st1_Tnew_E", int'(Tnew_E), 0);
    check("st1_addr_M", int'(reg_addr_M), 13);
    check("st1_addr_W", int'(reg_addr_W), 12);
    issue(1, 4, 1, 0, 0);
    check("st2_addr_E", int'(reg_addr_E), 0);
    check("st2_addr_M", int'(reg_addr_M), 0);
    check("st2_addr_W", int'(reg_addr_W), 13);
    issue(0, 4, 1, 0, 0);
    check("st_rel_addr_E", int'(reg_addr_E), 4);
    check("st_rel_Tnew_E", int'(Tnew_E), 1);

    // Same register in M and W: M wins; rs=0 never forwards.
    issue(0, 3, 1, 0, 0);
    issue(0, 3, 1, 0, 0);
    issue(0, 0, 0, 0, 3);
    check("mw_fwd_rt_E", int'(fwd_rt_E_op), 2);
    check("mw_fwd_rs_E", int'(fwd_rs_E_op), 0);
    issue(0, 0, 0, 0, 0);
    check("r0_addr_M", int'(reg_addr_M), 0);
    check("r0_fwd_rs_E", int'(fwd_rs_E_op), 0);

    // W-only forward on both operands.
    issue(0, 20, 1, 0, 0);
    issue(0, 0, 0, 0, 0);
    issue(0, 0, 0, 20, 20);
    check("w_fwd_rs_E", int'(fwd_rs_E_op), 1);
    check("w_fwd_rt_E", int'(fwd_rt_E_op), 1);

    // M match with Tnew_M!=0 falls through; later caught in W.
    issue(0, 21, 2, 0, 0);
    issue(0, 0, 0, 21, 0);
    check("nr_Tnew_M", int'(Tnew_M), 1);
    check("nr_fwd_rs_E", int'(fwd_rs_E_op), 0);
    issue(0, 0, 0, 21, 0);
    check("nr_fwd_rs_W", int'(fwd_rs_E_op), 1);

    // Tnew_D=3 ages to 2.
    issue(0, 22, 3, 0, 0);
    check("t3_Tnew_E", int'(Tnew_E), 3);
    issue(0, 0, 0, 0, 0);
    check("t3_Tnew_M", int'(Tnew_M), 2);

    // Store data forwarding in M.
    issue(0, 10, 1, 0, 0);
    issue(0, 0, 0, 0, 10);
    issue(0, 0, 0, 0, 0);
    check("st_rt_M", int'(rt_M), 10);
    check("st_fwd_rt_M_hit", int'(fwd_rt_M_op), 1);
    issue(0, 11, 1, 0, 0);
    issue(0, 0, 0, 0, 10);
    issue(0, 0, 0, 0, 0);
    check("st_addr_W", int'(reg_addr_W), 11);
    check("st_fwd_rt_M_miss", int'(fwd_rt_M_op), 0);

    // Asynchronous reset mid-stream with E/M/W = 5/6/7.
    issue(0, 7, 1, 7, 7);
    issue(0, 6, 2, 6, 6);
    issue(0, 5, 3, 5, 5);
    check("pre_rst_E", int'(reg_addr_E), 5);
    check("pre_rst_M", int'(reg_addr_M), 6);
    check("pre_rst_W", int'(reg_addr_W), 7);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    issue(0, 0, 0, 0, 0);
    check("post_rst_W", int'(reg_addr_W), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
